// File: rtl/op_link_health_mon.sv
// rtl/op_link_health_mon.sv - QPLL startup gate plus per-link fault watch driving the optical-link reset sequencer.
// One link monitor module is instantiated for DAQ and for TRG under a shared top FSM.

module op_link_health_mon_link #(
  parameter logic [15:0] HOLDOFF   = 16'd2000,
  parameter logic [3:0]  REQ_LEN   = 4'd11,
  parameter logic [2:0]  MAX_RETRY = 3'd3,
  parameter logic [3:0]  FLT_FILT  = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       fault,
  input  logic       clr_fail,
  output logic       op_rst,
  output logic       fail,
  output logic [2:0] retry
);

  localparam logic [1:0] S_MON  = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  flt_cnt_q, flt_cnt_d;
  logic [15:0] cln_cnt_q, cln_cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic        fail_q, fail_d;
  logic        op_rst_q, op_rst_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flt_cnt_d = flt_cnt_q;
    cln_cnt_d = cln_cnt_q;
    retry_d   = retry_q;
    fail_d    = fail_q;
    op_rst_d  = op_rst_q;
    if (!run) begin
      // Retry and the sticky fail verdict survive a QPLL drop; timers do not.
      state_d   = fail_q ? S_FAIL : S_MON;
      cnt_d     = 16'd0;
      flt_cnt_d = 4'd0;
      cln_cnt_d = 16'd0;
      op_rst_d  = 1'b0;
    end else begin
      case (state_q)
        S_MON: begin
          if (flt_cnt_q == FLT_FILT) begin
            flt_cnt_d = 4'd0;
            cln_cnt_d = 16'd0;
            if (retry_q < MAX_RETRY) begin
              state_d  = S_REQ;
              retry_d  = retry_q + 3'd1;
              op_rst_d = 1'b1;
              cnt_d    = 16'd1;
            end else begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
            end
          end else if (fault) begin
            flt_cnt_d = flt_cnt_q + 4'd1;
            cln_cnt_d = 16'd0;
          end else begin
            flt_cnt_d = 4'd0;
            if (cln_cnt_q < HOLDOFF) cln_cnt_d = cln_cnt_q + 16'd1;
            if (cln_cnt_d >= HOLDOFF) retry_d = 3'd0;
          end
        end
        S_REQ: begin
          if (cnt_q == {12'd0, REQ_LEN}) begin
            state_d  = S_HOLD;
            op_rst_d = 1'b0;
            cnt_d    = 16'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_HOLD: begin
          // The exit edge already counts as the first sample back in MON.
          if (cnt_q == HOLDOFF) begin
            state_d   = S_MON;
            cnt_d     = 16'd0;
            flt_cnt_d = fault ? 4'd1 : 4'd0;
            cln_cnt_d = fault ? 16'd0 : 16'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
    if (clr_fail) begin
      fail_d  = 1'b0;
      retry_d = 3'd0;
      if (state_q == S_FAIL || state_d == S_FAIL || state_d == S_REQ && state_q == S_MON) begin
        state_d   = S_MON;
        flt_cnt_d = 4'd0;
        cnt_d     = 16'd0;
        op_rst_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_MON;
      cnt_q     <= 16'd0;
      flt_cnt_q <= 4'd0;
      cln_cnt_q <= 16'd0;
      retry_q   <= 3'd0;
      fail_q    <= 1'b0;
      op_rst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flt_cnt_q <= flt_cnt_d;
      cln_cnt_q <= cln_cnt_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      op_rst_q  <= op_rst_d;
    end
  end

  assign op_rst = op_rst_q;
  assign fail   = fail_q;
  assign retry  = retry_q;

endmodule

module op_link_health_mon #(
  parameter logic [15:0] STRTUP_DLY = 16'd1000,
  parameter logic [3:0]  REQ_LEN    = 4'd11,
  parameter logic [15:0] HOLDOFF    = 16'd2000,
  parameter logic [2:0]  MAX_RETRY  = 3'd3,
  parameter logic [3:0]  FLT_FILT   = 4'd8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       QPLL_LOCK,
  input  logic       DAQ_PLL_LOCK,
  input  logic       TRG_PLL_LOCK,
  input  logic       DAQ_TX_FLT,
  input  logic       TRG_TX_FLT,
  input  logic       CLR_FAIL,
  output logic       STRTUP_OP_RST,
  output logic       DAQ_OP_RST,
  output logic       TRG_OP_RST,
  output logic       LINK_RDY,
  output logic       DAQ_FAIL,
  output logic       TRG_FAIL,
  output logic [2:0] DAQ_RETRY,
  output logic [2:0] TRG_RETRY
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STBL   = 3'd1;
  localparam logic [2:0] S_STRTUP = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        strtup_q, strtup_d;
  logic        link_rdy_q, link_rdy_d;
  logic        daq_fault, trg_fault;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    strtup_d   = strtup_q;
    link_rdy_d = link_rdy_q;
    if (state_q == S_IDLE) begin
      if (QPLL_LOCK) begin
        state_d = S_STBL;
        tcnt_d  = 16'd1;
      end
    end else if (!QPLL_LOCK) begin
      state_d    = S_IDLE;
      tcnt_d     = 16'd0;
      strtup_d   = 1'b0;
      link_rdy_d = 1'b0;
    end else begin
      case (state_q)
        S_STBL: begin
          if (tcnt_q == STRTUP_DLY) begin
            state_d  = S_STRTUP;
            strtup_d = 1'b1;
            tcnt_d   = 16'd1;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
        S_STRTUP: begin
          if (tcnt_q == {12'd0, REQ_LEN}) begin
            state_d  = S_SETTLE;
            strtup_d = 1'b0;
            tcnt_d   = 16'd1;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
        S_SETTLE: begin
          if (tcnt_q == HOLDOFF) begin
            state_d    = S_RUN;
            link_rdy_d = 1'b1;
            tcnt_d     = 16'd0;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tcnt_q     <= 16'd0;
      strtup_q   <= 1'b0;
      link_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      strtup_q   <= strtup_d;
      link_rdy_q <= link_rdy_d;
    end
  end

  assign daq_fault     = DAQ_TX_FLT | ~DAQ_PLL_LOCK;
  assign trg_fault     = TRG_TX_FLT | ~TRG_PLL_LOCK;
  assign STRTUP_OP_RST = strtup_q;
  assign LINK_RDY      = link_rdy_q;

  op_link_health_mon_link #(
    .HOLDOFF(HOLDOFF), .REQ_LEN(REQ_LEN), .MAX_RETRY(MAX_RETRY), .FLT_FILT(FLT_FILT)
  ) u_daq (
    .clk(CLK), .rst(RST), .run(link_rdy_q), .fault(daq_fault), .clr_fail(CLR_FAIL),
    .op_rst(DAQ_OP_RST), .fail(DAQ_FAIL), .retry(DAQ_RETRY)
  );

  op_link_health_mon_link #(
    .HOLDOFF(HOLDOFF), .REQ_LEN(REQ_LEN), .MAX_RETRY(MAX_RETRY), .FLT_FILT(FLT_FILT)
  ) u_trg (
    .clk(CLK), .rst(RST), .run(link_rdy_q), .fault(trg_fault), .clr_fail(CLR_FAIL),
    .op_rst(TRG_OP_RST), .fail(TRG_FAIL), .retry(TRG_RETRY)
  );

endmodule

// File: tb/tb_op_link_health_mon.sv
// tb/tb_op_link_health_mon.sv - event scoreboard bench for op_link_health_mon.
// Expected output transitions (edge, value) are queued by the stimulus; a monitor pops them on every observed change.

module tb_op_link_health_mon;

  logic       CLK = 1'b0;
  logic       RST, QPLL_LOCK, DAQ_PLL_LOCK, TRG_PLL_LOCK, DAQ_TX_FLT, TRG_TX_FLT, CLR_FAIL;
  logic       STRTUP_OP_RST, DAQ_OP_RST, TRG_OP_RST, LINK_RDY, DAQ_FAIL, TRG_FAIL;
  logic [2:0] DAQ_RETRY, TRG_RETRY;

  typedef struct {
    int id;
    int cyc;
    int val;
  } ev_t;

  ev_t   exp_q[$];
  int    edge_n = 0;
  int    total  = 0;
  int    bad    = 0;
  int    cur[8];
  int    prev[8];
  string names[8] = '{"STRTUP_OP_RST", "DAQ_OP_RST", "TRG_OP_RST", "LINK_RDY",
                      "DAQ_FAIL", "TRG_FAIL", "DAQ_RETRY", "TRG_RETRY"};

  op_link_health_mon #(
    .STRTUP_DLY(16'd20), .REQ_LEN(4'd11), .HOLDOFF(16'd50), .MAX_RETRY(3'd2), .FLT_FILT(4'd4)
  ) dut (
    .CLK(CLK), .RST(RST), .QPLL_LOCK(QPLL_LOCK), .DAQ_PLL_LOCK(DAQ_PLL_LOCK),
    .TRG_PLL_LOCK(TRG_PLL_LOCK), .DAQ_TX_FLT(DAQ_TX_FLT), .TRG_TX_FLT(TRG_TX_FLT),
    .CLR_FAIL(CLR_FAIL), .STRTUP_OP_RST(STRTUP_OP_RST), .DAQ_OP_RST(DAQ_OP_RST),
    .TRG_OP_RST(TRG_OP_RST), .LINK_RDY(LINK_RDY), .DAQ_FAIL(DAQ_FAIL), .TRG_FAIL(TRG_FAIL),
    .DAQ_RETRY(DAQ_RETRY), .TRG_RETRY(TRG_RETRY)
  );

  always #5 CLK = ~CLK;

  task automatic push(input int id, input int cyc, input int val);
    ev_t e;
    e.id  = id;
    e.cyc = cyc;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Returns at the falling edge just before edge e, so inputs set now are sampled at edge e.
  task automatic at_edge(input int e);
    while (edge_n < e - 1) @(negedge CLK);
  endtask

  // Monitor: timestamps every output transition and matches it against the queue.
  initial begin
    forever begin
      @(posedge CLK);
      edge_n++;
      #1;
      cur[0] = int'(STRTUP_OP_RST);
      cur[1] = int'(DAQ_OP_RST);
      cur[2] = int'(TRG_OP_RST);
      cur[3] = int'(LINK_RDY);
      cur[4] = int'(DAQ_FAIL);
      cur[5] = int'(TRG_FAIL);
      cur[6] = int'(DAQ_RETRY);
      cur[7] = int'(TRG_RETRY);
      if (edge_n == 2) begin
        for (int i = 0; i < 8; i++) begin
          total++;
          if (cur[i] != 0) begin
            bad++;
            $display("FAIL reset_%s: got %0d, required 0", names[i], cur[i]);
          end
        end
      end else if (edge_n > 2) begin
        for (int i = 0; i < 8; i++) begin
          if (cur[i] != prev[i]) begin
            int idx;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
              if (idx < 0 && exp_q[k].id == i) idx = k;
            end
            total++;
            if (idx < 0) begin
              bad++;
              $display("FAIL %s: got change to %0d at edge %0d, required no change",
                       names[i], cur[i], edge_n);
            end else begin
              if (exp_q[idx].cyc != edge_n || exp_q[idx].val != cur[i]) begin
                bad++;
                $display("FAIL %s: got value %0d at edge %0d, required value %0d at edge %0d",
                         names[i], cur[i], edge_n, exp_q[idx].val, exp_q[idx].cyc);
              end
              exp_q.delete(idx);
            end
          end
        end
      end
      for (int i = 0; i < 8; i++) prev[i] = cur[i];
    end
  end

  initial begin
    RST = 1'b1; QPLL_LOCK = 1'b0; DAQ_PLL_LOCK = 1'b1; TRG_PLL_LOCK = 1'b1;
    DAQ_TX_FLT = 1'b0; TRG_TX_FLT = 1'b0; CLR_FAIL = 1'b0;
    at_edge(3);  RST = 1'b0;

    // Startup: lock at 10 -> pulse on edges 30..40, ready at 10+20+11+50.
    at_edge(10); QPLL_LOCK = 1'b1;
    push(0, 30, 1); push(0, 41, 0); push(3, 91, 1);

    // Three fault samples stay below the filter threshold.
    at_edge(100); DAQ_TX_FLT = 1'b1;
    at_edge(103); DAQ_TX_FLT = 1'b0;

    // Four samples from 110: request 114..124, retry clears after 50 clean samples from 175.
    at_edge(110); DAQ_TX_FLT = 1'b1;
    push(1, 114, 1); push(1, 125, 0); push(6, 114, 1); push(6, 224, 0);
    at_edge(114); DAQ_TX_FLT = 1'b0;

    // Exhaustion on TRG: pulses at 244 and 309 (65 apart), fail at 374.
    at_edge(240); TRG_PLL_LOCK = 1'b0;
    push(2, 244, 1); push(2, 255, 0); push(7, 244, 1);
    push(2, 309, 1); push(2, 320, 0); push(7, 309, 2);
    push(5, 374, 1);
    at_edge(380); CLR_FAIL = 1'b1;
    push(5, 380, 0); push(7, 380, 0);
    push(2, 385, 1); push(2, 396, 0); push(7, 385, 1); push(7, 495, 0);
    at_edge(381); CLR_FAIL = 1'b0;
    at_edge(386); TRG_PLL_LOCK = 1'b1;

    // Simultaneous fault on both links, then clean recovery.
    at_edge(510); DAQ_TX_FLT = 1'b1; TRG_TX_FLT = 1'b1;
    push(1, 514, 1); push(1, 525, 0); push(2, 514, 1); push(2, 525, 0);
    push(6, 514, 1); push(6, 624, 0); push(7, 514, 1); push(7, 624, 0);
    at_edge(514); DAQ_TX_FLT = 1'b0; TRG_TX_FLT = 1'b0;

    // CLR_FAIL on the threshold edge suppresses the request.
    at_edge(640); DAQ_TX_FLT = 1'b1;
    at_edge(644); DAQ_TX_FLT = 1'b0; CLR_FAIL = 1'b1;
    at_edge(645); CLR_FAIL = 1'b0;

    // Reset during the fifth cycle of a DAQ pulse, then restart with a lock glitch.
    at_edge(660); DAQ_TX_FLT = 1'b1;
    push(1, 664, 1); push(6, 664, 1);
    push(1, 669, 0); push(6, 669, 0); push(3, 669, 0);
    at_edge(664); DAQ_TX_FLT = 1'b0;
    at_edge(669); RST = 1'b1;
    at_edge(670); RST = 1'b0;
    push(0, 706, 1); push(0, 717, 0); push(3, 767, 1);
    at_edge(685); QPLL_LOCK = 1'b0;
    at_edge(686); QPLL_LOCK = 1'b1;

    at_edge(800);
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no change, required value %0d at edge %0d",
               names[exp_q[0].id], exp_q[0].val, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
